// File: rtl/ser_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ser_tx : framed LSB-first serial transmitter, DIV clocks per bit.
//          Optional even-parity bit when SER_TX_PARITY_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
module ser_tx #(
  parameter int W   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data,
  input  logic         valid,
  output logic         ready,
  output logic         x,
  output logic         busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

`ifdef SER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic          x_q, x_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          last_cyc;
  logic [W-1:0]  shifted;
`ifdef SER_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    x_d      = x_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
`ifdef SER_TX_PARITY_EN
    par_d    = par_q;
`endif
    last_cyc = (cyc_q == CYC_LAST);
    shifted  = shreg_q >> 1;

    // Bit-period counter free-runs during a frame and wraps at each bit boundary.
    if (state_q != IDLE) begin
      cyc_d = last_cyc ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          shreg_d = data;
          bit_d   = '0;
          cyc_d   = '0;
          x_d     = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef SER_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: begin
        if (last_cyc) begin
          x_d     = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_cyc) begin
          if (bit_q == BIT_LAST) begin
`ifdef SER_TX_PARITY_EN
            x_d     = par_q;
            state_d = PAR;
`else
            x_d     = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shreg_d = shifted;
            bit_d   = bit_q + 1'b1;
            x_d     = shifted[0];
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      PAR: begin
        if (last_cyc) begin
          x_d     = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (last_cyc) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      x_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      x_q     <= x_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef SER_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign x     = x_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ser_tx : scoreboard bench for ser_tx (W=8/DIV=4 and W=1/DIV=1 instances).
//             Honours SER_TX_PARITY_EN. Rev 1.0
// ---------------------------------------------------------------------------
module tb_ser_tx;

  localparam int W   = 8;
  localparam int DIV = 4;
`ifdef SER_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int F  = (W + 2 + NPAR) * DIV;
  localparam int F1 = (1 + 2 + NPAR) * 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data  = '0;
  logic         valid = 1'b0;
  logic         ready, x, busy;
  logic [0:0]   data1  = '0;
  logic         valid1 = 1'b0;
  logic         ready1, x1, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic exp_q[$];

  ser_tx #(.W(W), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid),
    .ready(ready), .x(x), .busy(busy)
  );

  ser_tx #(.W(1), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .valid(valid1),
    .ready(ready1), .x(x1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for every cycle of one frame.
  function automatic void push_frame(input logic [7:0] word, input int w, input int div);
    logic p;
    p = 1'b0;
    for (int i = 0; i < w; i++) p ^= word[i];
    repeat (div) exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) repeat (div) exp_q.push_back(word[i]);
    if (NPAR == 1) repeat (div) exp_q.push_back(p);
    repeat (div) exp_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; data = 8'hFF; valid1 = 1'b1; data1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (x !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || x1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: x=%b ready=%b busy=%b x1=%b ready1=%b busy1=%b expected 1 1 0 1 1 0",
                 i, x, ready, busy, x1, ready1, busy1);
      end
    end
    valid = 1'b0; valid1 = 1'b0;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (x !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: x=%b ready=%b busy=%b expected 1 1 0", x, ready, busy);
    end
  endtask

  task automatic test_single(input logic [7:0] word, input string name);
    data = word; valid = 1'b1;
    n_chk++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: ready=%b expected 1", name, ready);
    end
    tick();
    valid = 1'b0;
    push_frame(word, W, DIV);
    for (int i = 0; i < F; i++) begin
      logic ex;
      ex = exp_q.pop_front();
      n_chk++;
      if (x !== ex || ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s c%0d: x=%b ready=%b busy=%b expected x=%b ready=0 busy=1", name, i, x, ready, busy, ex);
      end
      tick();
    end
    n_chk++;
    if (x !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_end: x=%b ready=%b busy=%b expected 1 1 0", name, x, ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    data = 8'h3C; valid = 1'b1;
    tick();
    push_frame(8'h3C, W, DIV);
    data = 8'hC3;
    t1 = cyc;
    for (int i = 0; i < F; i++) begin
      logic ex;
      ex = exp_q.pop_front();
      n_chk++;
      if (x !== ex || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_f1 c%0d: x=%b ready=%b expected x=%b ready=0", i, x, ready, ex);
      end
      tick();
    end
    n_chk++;
    if (x !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: x=%b ready=%b busy=%b expected 1 1 0", x, ready, busy);
    end
    tick();
    valid = 1'b0;
    push_frame(8'hC3, W, DIV);
    t2 = cyc;
    n_chk++;
    if (t2 - t1 !== F + 1) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles expected %0d", t2 - t1, F + 1);
    end
    for (int i = 0; i < F; i++) begin
      logic ex;
      ex = exp_q.pop_front();
      n_chk++;
      if (x !== ex || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_f2 c%0d: x=%b ready=%b expected x=%b ready=0", i, x, ready, ex);
      end
      tick();
    end
    n_chk++;
    if (x !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end: x=%b ready=%b expected 1 1", x, ready);
    end
  endtask

  task automatic test_abort();
    data = 8'h5A; valid = 1'b1;
    tick();
    valid = 1'b0;
    push_frame(8'h5A, W, DIV);
    for (int i = 0; i < 16; i++) begin
      logic ex;
      ex = exp_q.pop_front();
      n_chk++;
      if (x !== ex) begin
        n_fail++;
        $display("FAIL abort_pre c%0d: x=%b expected %b", i, x, ex);
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (x !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: x=%b ready=%b busy=%b expected 1 1 0", x, ready, busy);
    end
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_single(8'h96, "post_abort");
  endtask

  task automatic test_div1();
    data1 = 1'b1; valid1 = 1'b1;
    n_chk++;
    if (ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_ready: ready1=%b expected 1", ready1);
    end
    tick();
    valid1 = 1'b0;
    push_frame(8'h01, 1, 1);
    for (int i = 0; i < F1; i++) begin
      logic ex;
      ex = exp_q.pop_front();
      n_chk++;
      if (x1 !== ex || ready1 !== 1'b0 || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL div1 c%0d: x1=%b ready1=%b busy1=%b expected x1=%b ready1=0 busy1=1",
                 i, x1, ready1, busy1, ex);
      end
      tick();
    end
    n_chk++;
    if (x1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL div1_end: x1=%b ready1=%b busy1=%b expected 1 1 0", x1, ready1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "a5");
    test_single(8'h01, "x01");
    test_back_to_back();
    test_abort();
    test_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
